e_md_issue_queue: RTL and testbench

Issue buffer for the multiply/divide unit. Sits between the D/E pipeline registers and E_HILO. It queues up to DEPTH HI/LO operations (mult/multu/div/divu/mthi/mtlo) with their operands. It hands them to E_HILO one at a time: only when E_HILO reports neither Start nor Busy. It exports Pending so the hazard unit can stall mfhi/mflo until all queued work has retired.

---
 rtl/e_md_issue_queue_if.sv | 25 ++
 rtl/e_md_issue_queue.sv | 75 +++++++
 tb/tb_e_md_issue_queue.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/e_md_issue_queue_if.sv
// e_md_issue_queue_if: D-side enqueue port, E_HILO issue port and status of the mul/div issue queue
interface e_md_issue_queue_if #(parameter int AW = 2);
   logic          in_valid;
   logic          in_ready;
   logic [3:0]    in_type;
   logic [31:0]   in_a;
   logic [31:0]   in_b;
   logic          flush;
   logic          Start;
   logic          Busy;
   logic [3:0]    MDType;
   logic [31:0]   A;
   logic [31:0]   B;
   logic [AW:0]   count;
   logic          Pending;
   logic          drop;
   modport slave (
      input  in_valid, in_type, in_a, in_b, flush, Start, Busy,
      output in_ready, MDType, A, B, count, Pending, drop
   );
   modport master (
      output in_valid, in_type, in_a, in_b, flush, Start, Busy,
      input  in_ready, MDType, A, B, count, Pending, drop
   );
endinterface

// File: rtl/e_md_issue_queue.sv
// e_md_issue_queue: in-order HI/LO op buffer feeding E_HILO one op at a time
module e_md_issue_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic                clk,
   input  logic                reset,
   e_md_issue_queue_if.slave   q
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
   state_t state, state_nx;
   logic [3:0]    mem_type [DEPTH];
   logic [31:0]   mem_a    [DEPTH];
   logic [31:0]   mem_b    [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   cnt;
   logic [3:0]    md;
   logic [31:0]   a, b;
   logic          drop_r, legal, push, pop, ehilo_idle;
   assign legal      = q.in_type inside {[4'd1:4'd6]};
   assign ehilo_idle = ~q.Start & ~q.Busy;
   assign q.in_ready = cnt != (AW+1)'(DEPTH);
   assign push       = q.in_valid & q.in_ready & legal & ~q.flush;
   assign pop        = (state == IDLE) & (cnt != '0) & ehilo_idle & ~q.flush;
   assign q.MDType   = md;
   assign q.A        = a;
   assign q.B        = b;
   assign q.count    = cnt;
   assign q.drop     = drop_r;
   assign q.Pending  = (cnt != '0) | (state != IDLE) | q.Start | q.Busy;
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE)  ? (pop ? ISSUE : IDLE) :
                 (state == ISSUE) ? WAIT :
                 (ehilo_idle ? IDLE : WAIT);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
         md     <= '0;
         a      <= '0;
         b      <= '0;
         drop_r <= 1'b0;
      end else begin
         state  <= state_nx;
         drop_r <= q.in_valid & ~legal;
         if (pop) begin
            md     <= mem_type[rd_ptr];
            a      <= mem_a[rd_ptr];
            b      <= mem_b[rd_ptr];
            rd_ptr <= rd_ptr + 1'b1;
         end else if (state == ISSUE) begin
            md <= '0;
         end
         // pop is already gated by ~flush, so rd_ptr is stable when flushing
         if (q.flush) begin
            wr_ptr <= rd_ptr;
            cnt    <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_type[wr_ptr] <= q.in_type;
         mem_a[wr_ptr]    <= q.in_a;
         mem_b[wr_ptr]    <= q.in_b;
      end
   end
endmodule

// File: tb/tb_e_md_issue_queue.sv
// tb_e_md_issue_queue: directed stimulus with a scoreboard-driven issue monitor
module tb_e_md_issue_queue;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic busy_man = 1'b0;
   logic busy_auto = 1'b0;
   bit   auto_busy = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   logic [67:0] sb[$];
   logic [3:0]  prev_md = '0;
   logic        busy_prev = 1'b0;
   e_md_issue_queue_if #(.AW(2)) q ();
   e_md_issue_queue #(.DEPTH(4), .AW(2)) dut (.clk(clk), .reset(reset), .q(q));
   always #5 clk = ~clk;
   assign q.Busy = busy_man | busy_auto;
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic offer(input logic [3:0] t, input logic [31:0] a, input logic [31:0] b, input bit to_sb);
      q.in_valid = 1'b1;
      q.in_type  = t;
      q.in_a     = a;
      q.in_b     = b;
      if (to_sb) sb.push_back({t, a, b});
      step();
      q.in_valid = 1'b0;
   endtask
   task automatic wait_drain(input int max);
      bit done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         if (q.count == 0 && !q.Pending && sb.size() == 0) done = 1'b1;
         else step();
      end
      chk("drain", 32'(done), 32'd1);
   endtask
   // E_HILO stand-in: holds Busy for two cycles after each accepted op
   initial forever begin
      @(posedge clk);
      #1;
      if (auto_busy && q.MDType != 0) begin
         busy_auto = 1'b1;
         repeat (2) @(posedge clk);
         #1 busy_auto = 1'b0;
      end
   end
   always @(negedge clk) begin
      logic [67:0] e;
      if (q.MDType != 0) begin
         n_vec++;
         if (prev_md != 0 || busy_prev) begin
            n_err++;
            $display("FAIL issue_pulse: prev MDType %0d prev Busy %0d, required 0 and 0", prev_md, busy_prev);
         end
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_issue: MDType %0d A %0d B %0d, required no issue", q.MDType, q.A, q.B);
         end else begin
            e = sb.pop_front();
            if ({q.MDType, q.A, q.B} !== e) begin
               n_err++;
               $display("FAIL issue_order: got %0d/%0d/%0d expected %0d/%0d/%0d",
                        q.MDType, q.A, q.B, e[67:64], e[63:32], e[31:0]);
            end
         end
      end
      prev_md   = q.MDType;
      busy_prev = q.Busy;
   end
   initial begin
      q.in_valid = 1'b0;
      q.in_type  = '0;
      q.in_a     = '0;
      q.in_b     = '0;
      q.flush    = 1'b0;
      q.Start    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      step();
      chk("rst_count", 32'(q.count), 0);
      chk("rst_ready", 32'(q.in_ready), 1);
      chk("rst_mdtype", 32'(q.MDType), 0);
      chk("rst_pending", 32'(q.Pending), 0);
      chk("rst_drop", 32'(q.drop), 0);
      // single div into an idle queue
      offer(4'd3, 32'd12, 32'd4, 1'b1);
      chk("t1_count_push", 32'(q.count), 1);
      chk("t1_md_push", 32'(q.MDType), 0);
      step();
      chk("t1_md", 32'(q.MDType), 3);
      chk("t1_a", q.A, 12);
      chk("t1_b", q.B, 4);
      chk("t1_count_pop", 32'(q.count), 0);
      chk("t1_pending", 32'(q.Pending), 1);
      busy_man = 1'b1;
      step();
      chk("t1_md_clear", 32'(q.MDType), 0);
      chk("t1_a_hold", q.A, 12);
      repeat (2) step();
      chk("t1_pending_busy", 32'(q.Pending), 1);
      busy_man = 1'b0;
      step();
      chk("t1_pending_done", 32'(q.Pending), 0);
      // fill behind Busy, overflow attempt, then in-order drain
      busy_man = 1'b1;
      for (int i = 1; i <= 4; i++) offer(4'd1, 32'(i), 32'd10, 1'b1);
      chk("t2_count_full", 32'(q.count), 4);
      chk("t2_ready_full", 32'(q.in_ready), 0);
      offer(4'd1, 32'd5, 32'd10, 1'b0);
      chk("t2_count_5th", 32'(q.count), 4);
      auto_busy = 1'b1;
      busy_man  = 1'b0;
      wait_drain(80);
      // full queue: pop with a rejected push, then a push that wraps wr_ptr
      busy_man = 1'b1;
      offer(4'd5, 32'd100, 32'd0, 1'b1);
      offer(4'd6, 32'd101, 32'd0, 1'b1);
      offer(4'd5, 32'd102, 32'd0, 1'b1);
      offer(4'd6, 32'd103, 32'd0, 1'b1);
      chk("t3_count_full", 32'(q.count), 4);
      busy_man = 1'b0;
      offer(4'd6, 32'd200, 32'd0, 1'b0);
      chk("t3_count_pop", 32'(q.count), 3);
      chk("t3_md", 32'(q.MDType), 5);
      chk("t3_a", q.A, 100);
      offer(4'd6, 32'd200, 32'd0, 1'b1);
      chk("t3_count_refill", 32'(q.count), 4);
      chk("t3_ready", 32'(q.in_ready), 0);
      wait_drain(80);
      // flush with an op in flight and a simultaneous push
      auto_busy = 1'b0;
      offer(4'd3, 32'd7, 32'd1, 1'b1);
      offer(4'd3, 32'd8, 32'd1, 1'b0);
      busy_man = 1'b1;
      offer(4'd3, 32'd9, 32'd1, 1'b0);
      offer(4'd3, 32'd10, 32'd1, 1'b0);
      chk("t4_count_pre", 32'(q.count), 3);
      q.flush = 1'b1;
      offer(4'd4, 32'd99, 32'd9, 1'b0);
      q.flush = 1'b0;
      chk("t4_count_flush", 32'(q.count), 0);
      chk("t4_ready", 32'(q.in_ready), 1);
      chk("t4_pending_busy", 32'(q.Pending), 1);
      repeat (2) step();
      busy_man = 1'b0;
      step();
      chk("t4_pending_done", 32'(q.Pending), 0);
      repeat (8) step();
      chk("t4_count_end", 32'(q.count), 0);
      // illegal op codes
      offer(4'd0, 32'd1, 32'd2, 1'b0);
      chk("t5_drop0", 32'(q.drop), 1);
      chk("t5_count0", 32'(q.count), 0);
      step();
      chk("t5_drop_clear", 32'(q.drop), 0);
      offer(4'd9, 32'd3, 32'd4, 1'b0);
      chk("t5_drop9", 32'(q.drop), 1);
      chk("t5_count9", 32'(q.count), 0);
      chk("t5_md", 32'(q.MDType), 0);
      // asynchronous reset during ISSUE with two entries still queued
      busy_man = 1'b1;
      offer(4'd1, 32'd55, 32'd66, 1'b0);
      offer(4'd2, 32'd56, 32'd67, 1'b0);
      offer(4'd6, 32'd57, 32'd68, 1'b0);
      busy_man = 1'b0;
      step();
      chk("t6_md_issue", 32'(q.MDType), 1);
      chk("t6_a_issue", q.A, 55);
      chk("t6_count_issue", 32'(q.count), 2);
      #2 reset = 1'b0;
      #1;
      chk("t6_md_rst", 32'(q.MDType), 0);
      chk("t6_a_rst", q.A, 0);
      chk("t6_b_rst", q.B, 0);
      chk("t6_count_rst", 32'(q.count), 0);
      chk("t6_ready_rst", 32'(q.in_ready), 1);
      @(negedge clk) reset = 1'b1;
      repeat (10) step();
      chk("t6_count_after", 32'(q.count), 0);
      chk("t6_pending_after", 32'(q.Pending), 0);
      chk("sb_empty", 32'(sb.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
